dmem_block_responder: RTL and testbench

DMEM_BLOCK_RESPONDER -- requirements
Module: dmem_block_responder

---
 rtl/dmem_resp_pkg.sv | 17 +
 rtl/blk_store.sv | 26 ++
 rtl/dmem_block_responder.sv | 113 +++++++++++
 tb/tb_dmem_block_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and widths for the data-memory block responder.
// Block geometry, counter width and the responder FSM state type.
package dmem_resp_pkg;

    localparam int BLOCK_BITS  = 256;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_BITS    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESPOND,
        TURN
    } respState_t;

endpackage

// File: rtl/blk_store.sv
// Single-port block storage: synchronous write, asynchronous read.
// Contents are deliberately not reset so data survives a responder reset.
module blk_store
    import dmem_resp_pkg::*;
#(
    parameter int NUM_BLOCKS = 64,
    parameter int IDX_BITS   = $clog2(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  writeEnable,
    input  logic [IDX_BITS-1:0]   index,
    input  logic [BLOCK_BITS-1:0] writeData,
    output logic [BLOCK_BITS-1:0] readData
);

    logic [BLOCK_BITS-1:0] mem [NUM_BLOCKS];

    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem[index] <= writeData;
        end
    end

    assign readData = mem[index];

endmodule

// File: rtl/dmem_block_responder.sv
// Fixed-latency 256-bit block memory responder for a data cache miss path.
// Accepts one read or write at a time; writes win when both are requested.
module dmem_block_responder
    import dmem_resp_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int NUM_BLOCKS = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           blk_addr,
    input  logic                  dBlkRead,
    input  logic                  dBlkWrite,
    input  logic [BLOCK_BITS-1:0] block_write_2DM,
    output logic [BLOCK_BITS-1:0] block_read_fDM,
    output logic                  block_read_fDM_valid,
    output logic                  block_write_fDM_valid,
    output logic                  busy
);

    localparam int IDX_BITS = $clog2(NUM_BLOCKS);

    respState_t            state;
    respState_t            nextState;
    logic [CNT_BITS-1:0]   cnt;
    logic                  opIsWrite;
    logic [IDX_BITS-1:0]   reqIdx;
    logic [BLOCK_BITS-1:0] reqData;
    logic [BLOCK_BITS-1:0] lastRead;
    logic [BLOCK_BITS-1:0] storeRdata;
    logic                  accept;
    logic                  respondRead;
    logic                  respondWrite;
    logic                  storeWe;
    logic                  unusedAddrBits;

    assign accept       = (state == IDLE) && (dBlkRead || dBlkWrite);
    assign respondRead  = (state == RESPOND) && !opIsWrite;
    assign respondWrite = (state == RESPOND) && opIsWrite;

    // Only the block index bits matter; offset and high bits wrap away.
    assign unusedAddrBits = ^{blk_addr[31:IDX_BITS+OFFSET_BITS], blk_addr[OFFSET_BITS-1:0]};

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            lastRead <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                cnt <= CNT_BITS'(LATENCY - 1);
            end else if ((state == RD_WAIT || state == WR_WAIT) && cnt != '0) begin
                cnt <= cnt - CNT_BITS'(1);
            end
            if (respondRead) begin
                lastRead <= storeRdata;
            end
        end
    end

    // Request snapshot taken only at acceptance so the requester may change inputs freely afterwards.
    always_ff @(posedge CLK) begin
        if (accept) begin
            reqIdx    <= blk_addr[IDX_BITS+OFFSET_BITS-1:OFFSET_BITS];
            opIsWrite <= dBlkWrite;
            if (dBlkWrite) begin
                reqData <= block_write_2DM;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (dBlkWrite) begin
                    nextState = WR_WAIT;
                end else if (dBlkRead) begin
                    nextState = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt == '0) begin
                    nextState = RESPOND;
                end
            end
            RESPOND: nextState = TURN;
            TURN:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Commit is qualified by RESET so a reset landing in RESPOND leaves storage untouched.
    assign storeWe = respondWrite && RESET;

    blk_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_BITS   (IDX_BITS)
    ) uStore (
        .clk         (CLK),
        .writeEnable (storeWe),
        .index       (reqIdx),
        .writeData   (reqData),
        .readData    (storeRdata)
    );

    assign busy                  = (state != IDLE);
    assign block_read_fDM_valid  = respondRead;
    assign block_write_fDM_valid = respondWrite;
    assign block_read_fDM        = respondRead ? storeRdata : lastRead;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Randomized self-checking bench for dmem_block_responder against an array model of block memory.
// Each scenario task drives its own stimulus and compares against model-derived expectations.
module tb_dmem_block_responder;

    localparam int LAT = 4;
    localparam int NB  = 64;

    logic         CLK;
    logic         RESET;
    logic [31:0]  blk_addr;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [255:0] block_write_2DM;
    logic [255:0] block_read_fDM;
    logic         block_read_fDM_valid;
    logic         block_write_fDM_valid;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [255:0] model [NB];
    bit           known [NB];

    dmem_block_responder #(
        .LATENCY    (LAT),
        .NUM_BLOCKS (NB)
    ) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .blk_addr              (blk_addr),
        .dBlkRead              (dBlkRead),
        .dBlkWrite             (dBlkWrite),
        .block_write_2DM       (block_write_2DM),
        .block_read_fDM        (block_read_fDM),
        .block_read_fDM_valid  (block_read_fDM_valid),
        .block_write_fDM_valid (block_write_fDM_valid),
        .busy                  (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int idxOf(input logic [31:0] a);
        return int'((a / 32'd32) % 32'(NB));
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Runs one transaction from an idle DUT and reports what was observed; callers do the judging.
    task automatic runTxn(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                          input bit scramble, input bit dropEarly,
                          output int validAt, output int pulseCount, output int otherPulses,
                          output logic [255:0] rdData, output logic [255:0] holdData,
                          output bit busyOk, output bit idleAfter);
        logic myValid;
        logic otherValid;
        @(negedge CLK);
        blk_addr        = addr;
        block_write_2DM = data;
        dBlkWrite       = wr;
        dBlkRead        = !wr;
        @(posedge CLK);
        validAt     = 0;
        pulseCount  = 0;
        otherPulses = 0;
        busyOk      = 1'b1;
        rdData      = '0;
        holdData    = '0;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge CLK);
            myValid    = wr ? block_write_fDM_valid : block_read_fDM_valid;
            otherValid = wr ? block_read_fDM_valid : block_write_fDM_valid;
            if (myValid === 1'b1) begin
                pulseCount++;
                if (validAt == 0) begin
                    validAt = k;
                    rdData  = block_read_fDM;
                end
                dBlkRead  = 1'b0;
                dBlkWrite = 1'b0;
            end
            if (otherValid === 1'b1) otherPulses++;
            if (k <= LAT + 2 && busy !== 1'b1) busyOk = 1'b0;
            if (k == LAT + 2) holdData = block_read_fDM;
            if (k == 1 && scramble) begin
                blk_addr        = $urandom;
                block_write_2DM = rand256();
            end
            if (k == 1 && dropEarly) begin
                dBlkRead  = 1'b0;
                dBlkWrite = 1'b0;
            end
        end
        idleAfter = (busy === 1'b0);
        dBlkRead  = 1'b0;
        dBlkWrite = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; dBlkRead = 1'b0; dBlkWrite = 1'b0;
        blk_addr = '0; block_write_2DM = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (block_read_fDM_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got %b want 0", block_read_fDM_valid); end
        checks++; if (block_write_fDM_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wvalid got %b want 0", block_write_fDM_valid); end
        checks++; if (block_read_fDM !== 256'd0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", block_read_fDM); end
        RESET = 1'b1;
    endtask

    task automatic test_write_latency();
        int va, pc, op; logic [255:0] rd, hd; bit bo, ia;
        logic [255:0] d = {32{8'hA5}};
        runTxn(1'b1, 32'h40, d, 1'b0, 1'b0, va, pc, op, rd, hd, bo, ia);
        model[idxOf(32'h40)] = d; known[idxOf(32'h40)] = 1'b1;
        checks++; if (va != LAT + 1) begin errors++; $display("[TB] FAIL wr_latency got %0d want %0d", va, LAT + 1); end
        checks++; if (pc != 1) begin errors++; $display("[TB] FAIL wr_pulses got %0d want 1", pc); end
        checks++; if (op != 0) begin errors++; $display("[TB] FAIL wr_stray_rvalid got %0d want 0", op); end
        checks++; if (!bo) begin errors++; $display("[TB] FAIL wr_busy got low want high"); end
        checks++; if (!ia) begin errors++; $display("[TB] FAIL wr_idle_after got busy want idle"); end
    endtask

    task automatic test_offset_read();
        int va, pc, op; logic [255:0] rd, hd; bit bo, ia;
        runTxn(1'b0, 32'h5F, '0, 1'b0, 1'b0, va, pc, op, rd, hd, bo, ia);
        checks++; if (va != LAT + 1) begin errors++; $display("[TB] FAIL rd_latency got %0d want %0d", va, LAT + 1); end
        checks++; if (pc != 1) begin errors++; $display("[TB] FAIL rd_pulses got %0d want 1", pc); end
        checks++; if (rd !== model[idxOf(32'h5F)]) begin errors++; $display("[TB] FAIL rd_offset_data got %h want %h", rd, model[idxOf(32'h5F)]); end
        checks++; if (hd !== model[idxOf(32'h5F)]) begin errors++; $display("[TB] FAIL rd_hold got %h want %h", hd, model[idxOf(32'h5F)]); end
        checks++; if (op != 0) begin errors++; $display("[TB] FAIL rd_stray_wvalid got %0d want 0", op); end
    endtask

    task automatic test_simultaneous();
        int wAt = 0, rAt = 0, wCnt = 0, rCnt = 0;
        logic [255:0] rd = '0;
        logic [255:0] d = 256'h1234;
        @(negedge CLK);
        blk_addr = 32'h80; block_write_2DM = d; dBlkWrite = 1'b1; dBlkRead = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 2 * LAT + 8; k++) begin
            @(negedge CLK);
            if (block_write_fDM_valid === 1'b1) begin
                wCnt++; if (wAt == 0) wAt = k; dBlkWrite = 1'b0;
            end
            if (block_read_fDM_valid === 1'b1) begin
                rCnt++; if (rAt == 0) begin rAt = k; rd = block_read_fDM; end dBlkRead = 1'b0;
            end
        end
        dBlkRead = 1'b0; dBlkWrite = 1'b0;
        model[idxOf(32'h80)] = d; known[idxOf(32'h80)] = 1'b1;
        checks++; if (wAt != LAT + 1) begin errors++; $display("[TB] FAIL both_wr_at got %0d want %0d", wAt, LAT + 1); end
        checks++; if (rAt != 2 * LAT + 4) begin errors++; $display("[TB] FAIL both_rd_at got %0d want %0d", rAt, 2 * LAT + 4); end
        checks++; if (rd !== d) begin errors++; $display("[TB] FAIL both_rd_data got %h want %h", rd, d); end
        checks++; if (wCnt != 1 || rCnt != 1) begin errors++; $display("[TB] FAIL both_pulses got w%0d r%0d want w1 r1", wCnt, rCnt); end
    endtask

    task automatic test_wrap();
        int va, pc, op; logic [255:0] rd, hd; bit bo, ia;
        runTxn(1'b1, 32'h800, 256'h7, 1'b0, 1'b0, va, pc, op, rd, hd, bo, ia);
        model[idxOf(32'h800)] = 256'h7; known[idxOf(32'h800)] = 1'b1;
        runTxn(1'b0, 32'h0, '0, 1'b0, 1'b0, va, pc, op, rd, hd, bo, ia);
        checks++; if (rd !== 256'h7) begin errors++; $display("[TB] FAIL wrap_data got %h want 7", rd); end
    endtask

    task automatic test_scramble();
        int va, pc, op; logic [255:0] rd, hd; bit bo, ia;
        logic [255:0] d = rand256();
        runTxn(1'b1, 32'hC0, d, 1'b1, 1'b0, va, pc, op, rd, hd, bo, ia);
        model[idxOf(32'hC0)] = d; known[idxOf(32'hC0)] = 1'b1;
        runTxn(1'b0, 32'hC0, '0, 1'b0, 1'b0, va, pc, op, rd, hd, bo, ia);
        checks++; if (rd !== d) begin errors++; $display("[TB] FAIL scramble_data got %h want %h", rd, d); end
    endtask

    task automatic test_drop_early();
        int va, pc, op; logic [255:0] rd, hd; bit bo, ia;
        runTxn(1'b0, 32'h80, '0, 1'b0, 1'b1, va, pc, op, rd, hd, bo, ia);
        checks++; if (va != LAT + 1) begin errors++; $display("[TB] FAIL drop_latency got %0d want %0d", va, LAT + 1); end
        checks++; if (rd !== model[idxOf(32'h80)]) begin errors++; $display("[TB] FAIL drop_data got %h want %h", rd, model[idxOf(32'h80)]); end
    endtask

    task automatic test_reset_mid();
        int va, pc, op, stray = 0; logic [255:0] rd, hd; bit bo, ia;
        @(negedge CLK);
        blk_addr = 32'h40; block_write_2DM = rand256(); dBlkWrite = 1'b1; dBlkRead = 1'b0;
        @(posedge CLK);
        repeat (2) @(negedge CLK);
        RESET = 1'b0; dBlkWrite = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        checks++; if (block_read_fDM !== 256'd0) begin errors++; $display("[TB] FAIL midrst_rdata got %h want 0", block_read_fDM); end
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (block_write_fDM_valid !== 1'b0 || block_read_fDM_valid !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("[TB] FAIL midrst_valids got %0d want 0", stray); end
        runTxn(1'b0, 32'h40, '0, 1'b0, 1'b0, va, pc, op, rd, hd, bo, ia);
        checks++; if (rd !== model[idxOf(32'h40)]) begin errors++; $display("[TB] FAIL midrst_data got %h want %h", rd, model[idxOf(32'h40)]); end
    endtask

    task automatic test_random();
        int va, pc, op; logic [255:0] rd, hd; bit bo, ia;
        bit wr, scr, drp; logic [31:0] a; logic [255:0] d; int ix;
        for (int n = 0; n < 40; n++) begin
            wr  = 1'($urandom_range(0, 1));
            scr = ($urandom_range(0, 3) == 0);
            drp = ($urandom_range(0, 3) == 0);
            a   = (n < 20 || wr) ? $urandom : {$urandom_range(0, 3) == 0 ? 32'h0 : $urandom};
            d   = rand256();
            ix  = idxOf(a);
            runTxn(wr, a, d, scr, drp, va, pc, op, rd, hd, bo, ia);
            checks++; if (va != LAT + 1 || pc != 1) begin errors++; $display("[TB] FAIL rand_timing n=%0d got at%0d x%0d want at%0d x1", n, va, pc, LAT + 1); end
            if (!wr && known[ix]) begin
                checks++; if (rd !== model[ix]) begin errors++; $display("[TB] FAIL rand_data n=%0d got %h want %h", n, rd, model[ix]); end
            end
            if (wr) begin
                model[ix] = d; known[ix] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NB; i++) known[i] = 1'b0;
        test_reset();
        test_write_latency();
        test_offset_read();
        test_simultaneous();
        test_wrap();
        test_scramble();
        test_drop_early();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
